// File: rtl/ula_op_sequencer.sv
// Keypad-driven sequencer for the ULA: turns strobed key codes into two 2-digit operands and an
// operation, launches the ALU with a start/done handshake and holds the result or error for display.
module ula_op_sequencer #(
    parameter int         TIMEOUT_CYC = 1024,
    parameter logic [7:0] K_ADD       = 8'd10,
    parameter logic [7:0] K_SUB       = 8'd11,
    parameter logic [7:0] K_MUL       = 8'd12,
    parameter logic [7:0] K_DIV       = 8'd13,
    parameter logic [7:0] K_EQ        = 8'd14,
    parameter logic [7:0] K_DEF_A     = 8'd15,
    parameter logic [7:0] K_CLEAR     = 8'd16,
    parameter logic [7:0] K_ON_OFF    = 8'd18,
    parameter logic [7:0] K_DEF_B     = 8'd19
) (
    input  logic               CLOCK_50,
    input  logic               RESET_N,
    input  logic [7:0]         data,
    input  logic               validate,
    input  logic               alu_done,
    input  logic               alu_err,
    input  logic signed [15:0] alu_result,
    output logic [7:0]         out_A,
    output logic [7:0]         out_B,
    output logic [1:0]         alu_op,
    output logic               alu_start,
    output logic signed [15:0] result,
    output logic               result_valid,
    output logic               error,
    output logic               power_on,
    output logic               busy
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {
        S_OFF, S_IDLE, S_EDIT_A, S_EDIT_B, S_WAIT, S_SHOW, S_ERROR
    } state_t;

    state_t             r_state;
    logic [2:0]         r_v_sync;
    logic [1:0]         r_cnt_A;
    logic [1:0]         r_cnt_B;
    logic               r_op_set;
    logic [TW-1:0]      r_timer;
    logic [7:0]         r_out_A;
    logic [7:0]         r_out_B;
    logic [1:0]         r_alu_op;
    logic               r_alu_start;
    logic signed [15:0] r_result;
    logic               r_result_valid;
    logic               r_error;
    logic               r_power_on;
    logic               r_busy;

    logic               w_key_evt;
    logic               w_is_digit;
    logic               w_is_op;
    logic [1:0]         w_op_code;

    // Two flops resynchronise the asynchronous strobe; the third gives the rising-edge detect.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) r_v_sync <= 3'b000;
        else          r_v_sync <= {r_v_sync[1:0], validate};
    end

    assign w_key_evt  = r_v_sync[1] & ~r_v_sync[2];
    assign w_is_digit = (data <= 8'd9);

    always_comb begin
        w_is_op   = 1'b1;
        w_op_code = 2'b00;
        if      (data == K_ADD) w_op_code = 2'b00;
        else if (data == K_SUB) w_op_code = 2'b01;
        else if (data == K_MUL) w_op_code = 2'b10;
        else if (data == K_DIV) w_op_code = 2'b11;
        else                    w_is_op   = 1'b0;
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state        <= S_OFF;
            r_cnt_A        <= 2'd0;
            r_cnt_B        <= 2'd0;
            r_op_set       <= 1'b0;
            r_timer        <= '0;
            r_out_A        <= 8'd0;
            r_out_B        <= 8'd0;
            r_alu_op       <= 2'b00;
            r_alu_start    <= 1'b0;
            r_result       <= 16'sd0;
            r_result_valid <= 1'b0;
            r_error        <= 1'b0;
            r_power_on     <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            r_alu_start <= 1'b0;
            if (r_state == S_OFF) begin
                if (w_key_evt && data == K_ON_OFF) begin
                    r_state    <= S_IDLE;
                    r_power_on <= 1'b1;
                end
            end else if (w_key_evt && (data == K_ON_OFF || data == K_CLEAR)) begin
                // Power-off and clear share the wipe; both also abort an operation in flight.
                r_state        <= (data == K_ON_OFF) ? S_OFF : S_IDLE;
                r_power_on     <= (data != K_ON_OFF);
                r_cnt_A        <= 2'd0;
                r_cnt_B        <= 2'd0;
                r_op_set       <= 1'b0;
                r_timer        <= '0;
                r_out_A        <= 8'd0;
                r_out_B        <= 8'd0;
                r_alu_op       <= 2'b00;
                r_result       <= 16'sd0;
                r_result_valid <= 1'b0;
                r_error        <= 1'b0;
                r_busy         <= 1'b0;
            end else if (r_state == S_WAIT) begin
                // A done coinciding with our own start pulse is stale and must not complete the op.
                if (alu_done && !r_alu_start) begin
                    r_busy <= 1'b0;
                    if (alu_err) begin
                        r_error        <= 1'b1;
                        r_result_valid <= 1'b0;
                        r_state        <= S_ERROR;
                    end else begin
                        r_result       <= alu_result;
                        r_result_valid <= 1'b1;
                        r_state        <= S_SHOW;
                    end
                end else if (r_timer == TW'(TIMEOUT_CYC - 1)) begin
                    r_error <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_ERROR;
                end else begin
                    r_timer <= r_timer + 1'b1;
                end
            end else if (w_key_evt) begin
                if (data == K_DEF_A) begin
                    r_out_A        <= 8'd0;
                    r_cnt_A        <= 2'd0;
                    r_result_valid <= 1'b0;
                    r_error        <= 1'b0;
                    r_state        <= S_EDIT_A;
                end else if (data == K_DEF_B) begin
                    r_out_B        <= 8'd0;
                    r_cnt_B        <= 2'd0;
                    r_result_valid <= 1'b0;
                    r_error        <= 1'b0;
                    r_state        <= S_EDIT_B;
                end else if (w_is_digit && r_state == S_EDIT_A) begin
                    if (r_cnt_A == 2'd0) begin
                        r_out_A <= data;
                        r_cnt_A <= 2'd1;
                    end else if (r_cnt_A == 2'd1) begin
                        r_out_A <= (r_out_A << 3) + (r_out_A << 1) + data;
                        r_cnt_A <= 2'd2;
                    end
                end else if (w_is_digit && r_state == S_EDIT_B) begin
                    if (r_cnt_B == 2'd0) begin
                        r_out_B <= data;
                        r_cnt_B <= 2'd1;
                    end else if (r_cnt_B == 2'd1) begin
                        r_out_B <= (r_out_B << 3) + (r_out_B << 1) + data;
                        r_cnt_B <= 2'd2;
                    end
                end else if (w_is_op && r_state != S_ERROR) begin
                    r_alu_op <= w_op_code;
                    r_op_set <= 1'b1;
                end else if (data == K_EQ && r_state != S_ERROR && r_op_set) begin
                    r_alu_start <= 1'b1;
                    r_busy      <= 1'b1;
                    r_timer     <= '0;
                    r_state     <= S_WAIT;
                end
            end
        end
    end

    assign out_A        = r_out_A;
    assign out_B        = r_out_B;
    assign alu_op       = r_alu_op;
    assign alu_start    = r_alu_start;
    assign result       = r_result;
    assign result_valid = r_result_valid;
    assign error        = r_error;
    assign power_on     = r_power_on;
    assign busy         = r_busy;

endmodule
